// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline: PC, IF/ID and ID/EX control,
// multi-cycle EX wait, halt drain sequence and saturating stall/flush counters.
module pipeline_hazard_ctrl #(
  parameter int CNT_W        = 32,
  parameter int DRAIN_CYCLES = 3,
  parameter int MC_TIMEOUT   = 64
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_redirect,
  input  logic             ex_mc_start,
  input  logic             ex_mc_done,
  input  logic             imem_valid,
  input  logic             dmem_busy,
  input  logic             halt_req,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             back_hold,
  output logic             halted,
  output logic             mc_timeout,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic [1:0]       dbg_state
);

  localparam int TMR_W = (MC_TIMEOUT > 1) ? $clog2(MC_TIMEOUT) : 1;
  localparam int DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MC_TIMEOUT - 1);
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_EX_WAIT = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_HALTED  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [DRN_W-1:0] drain_q, drain_d;
  logic             mc_timeout_q, mc_timeout_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;
  logic             flush_ev;
  logic             lu;

  // Register x0 is hard-wired zero, so a load targeting it never creates a hazard.
  assign lu = ex_mem_read && (ex_rd != 5'd0) &&
              ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_RUN;
      timer_q       <= '0;
      drain_q       <= '0;
      mc_timeout_q  <= 1'b0;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      drain_q       <= drain_d;
      mc_timeout_q  <= mc_timeout_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  // imem_valid is the fetch side's valid; the fetch path sees pc_write as its ready,
  // so an instruction is consumed only in a cycle where both are high.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    drain_d      = drain_q;
    mc_timeout_d = mc_timeout_q;
    pc_write     = 1'b0;
    ifid_write   = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    back_hold    = 1'b0;
    halted       = 1'b0;
    flush_ev     = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (dmem_busy) begin
          back_hold = 1'b1;
        end else if (ex_redirect) begin
          pc_write   = 1'b1;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          flush_ev   = 1'b1;
        end else if (ex_mc_start) begin
          back_hold = 1'b1;
          state_d   = ST_EX_WAIT;
          timer_d   = '0;
        end else if (lu) begin
          idex_flush = 1'b1;
        end else if (halt_req) begin
          ifid_flush = 1'b1;
          state_d    = ST_DRAIN;
          drain_d    = '0;
        end else if (!imem_valid) begin
          ifid_flush = 1'b1;
        end else begin
          pc_write   = 1'b1;
          ifid_write = 1'b1;
        end
      end

      ST_EX_WAIT: begin
        timer_d = timer_q + TMR_W'(1);
        if (ex_mc_done) begin
          state_d = ST_RUN;
        end else if (timer_q == TMR_LAST) begin
          mc_timeout_d = 1'b1;
          state_d      = ST_RUN;
        end else begin
          back_hold = 1'b1;
        end
      end

      ST_DRAIN: begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        // A busy data memory stalls the back end, so that cycle drains nothing.
        if (dmem_busy) begin
          back_hold = 1'b1;
        end else if (drain_q == DRN_LAST) begin
          state_d = ST_HALTED;
        end else begin
          drain_d = drain_q + DRN_W'(1);
        end
      end

      ST_HALTED: begin
        halted    = 1'b1;
        back_hold = 1'b1;
      end

      default: state_d = ST_RUN;
    endcase

    if (!reset_n) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      back_hold  = 1'b0;
      halted     = 1'b0;
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if ((state_q != ST_HALTED) && !pc_write && (stall_count_q != '1))
      stall_count_d = stall_count_q + CNT_W'(1);
    if (flush_ev && (flush_count_q != '1))
      flush_count_d = flush_count_q + CNT_W'(1);
  end

  assign mc_timeout  = mc_timeout_q;
  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed hazard scenarios followed by random traffic,
// every cycle compared against a cycle-level behavioural model of the sequencer.
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W        = 4;
  localparam int DRAIN_CYCLES = 3;
  localparam int MC_TIMEOUT   = 64;
  localparam int CNT_MAX      = (1 << CNT_W) - 1;

  // Model modes, matching the debug state output numbering.
  localparam int M_RUN = 0, M_WAIT = 1, M_DRAIN = 2, M_HALT = 3;

  logic             clock = 1'b0;
  logic             reset_n = 1'b1;
  logic [4:0]       id_rs1, id_rs2, ex_rd;
  logic             id_uses_rs1, id_uses_rs2, ex_mem_read, ex_redirect;
  logic             ex_mc_start, ex_mc_done, imem_valid, dmem_busy, halt_req;
  logic             pc_write, ifid_write, ifid_flush, idex_flush, back_hold, halted;
  logic             mc_timeout;
  logic [CNT_W-1:0] stall_count, flush_count;
  logic [1:0]       dbg_state;

  pipeline_hazard_ctrl #(
    .CNT_W(CNT_W), .DRAIN_CYCLES(DRAIN_CYCLES), .MC_TIMEOUT(MC_TIMEOUT)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect),
    .ex_mc_start(ex_mc_start), .ex_mc_done(ex_mc_done), .imem_valid(imem_valid),
    .dmem_busy(dmem_busy), .halt_req(halt_req),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .back_hold(back_hold), .halted(halted),
    .mc_timeout(mc_timeout), .stall_count(stall_count), .flush_count(flush_count),
    .dbg_state(dbg_state)
  );

  // Clock and reset
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state: mode, cycles spent waiting, drain cycles still owed,
  // sticky timeout flag and unbounded event tallies (saturation applied on compare).
  int m_mode, m_wait, m_drain_left, m_stall, m_flush;
  bit m_to;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      if (n_errors <= 40)
        $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v > CNT_MAX) ? CNT_MAX : v;
  endfunction

  task automatic model_init();
    m_mode = M_RUN; m_wait = 0; m_drain_left = 0; m_stall = 0; m_flush = 0; m_to = 0;
  endtask

  // Driver tasks
  task automatic set_idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    ex_rd = 5'd0; ex_mem_read = 0; ex_redirect = 0; ex_mc_start = 0; ex_mc_done = 0;
    imem_valid = 1; dmem_busy = 0; halt_req = 0;
  endtask

  task automatic set_random(input int done_pct);
    id_rs1      = 5'($urandom_range(0, 3));
    id_rs2      = 5'($urandom_range(0, 3));
    ex_rd       = 5'($urandom_range(0, 3));
    id_uses_rs1 = 1'($urandom_range(0, 1));
    id_uses_rs2 = 1'($urandom_range(0, 1));
    ex_mem_read = ($urandom_range(0, 99) < 40);
    ex_redirect = ($urandom_range(0, 99) < 10);
    ex_mc_start = ($urandom_range(0, 99) < 6);
    ex_mc_done  = ($urandom_range(0, 99) < done_pct);
    imem_valid  = ($urandom_range(0, 99) < 85);
    dmem_busy   = ($urandom_range(0, 99) < 15);
    halt_req    = ($urandom_range(0, 99) < 2);
  endtask

  // Asserted between edges: outputs must take their reset values at once.
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check_val("rst_ctrl", {pc_write, ifid_write, ifid_flush, idex_flush, back_hold, halted},
              32'b001100);
    check_val("rst_mc_timeout", 32'(mc_timeout), 32'd0);
    check_val("rst_stall_count", 32'(stall_count), 32'd0);
    check_val("rst_flush_count", 32'(flush_count), 32'd0);
    check_val("rst_state", 32'(dbg_state), 32'(M_RUN));
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    model_init();
  endtask

  // One cycle: inputs are already driven at the falling edge; compare, then advance model.
  task automatic step();
    bit lu, e_pc, e_ifw, e_iff, e_idf, e_bh, e_hlt, flush_ev;
    int n_mode, n_wait, n_drain_left;
    bit n_to;
    #2;
    lu = ex_mem_read && (ex_rd != 0) &&
         ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    {e_pc, e_ifw, e_iff, e_idf, e_bh, e_hlt, flush_ev} = '0;
    n_mode = m_mode; n_wait = m_wait; n_drain_left = m_drain_left; n_to = m_to;

    if (m_mode == M_RUN) begin
      if (dmem_busy) e_bh = 1;
      else if (ex_redirect) begin e_pc = 1; e_iff = 1; e_idf = 1; flush_ev = 1; end
      else if (ex_mc_start) begin e_bh = 1; n_mode = M_WAIT; n_wait = 0; end
      else if (lu) e_idf = 1;
      else if (halt_req) begin e_iff = 1; n_mode = M_DRAIN; n_drain_left = DRAIN_CYCLES; end
      else if (!imem_valid) e_iff = 1;
      else begin e_pc = 1; e_ifw = 1; end
    end else if (m_mode == M_WAIT) begin
      n_wait = m_wait + 1;
      if (ex_mc_done) n_mode = M_RUN;
      else if (n_wait == MC_TIMEOUT) begin n_mode = M_RUN; n_to = 1; end
      else e_bh = 1;
    end else if (m_mode == M_DRAIN) begin
      e_iff = 1; e_idf = 1;
      if (dmem_busy) e_bh = 1;
      else begin
        n_drain_left = m_drain_left - 1;
        if (n_drain_left == 0) n_mode = M_HALT;
      end
    end else begin
      e_hlt = 1; e_bh = 1;
    end

    check_val("ctrl", {pc_write, ifid_write, ifid_flush, idex_flush, back_hold, halted},
              {26'd0, e_pc, e_ifw, e_iff, e_idf, e_bh, e_hlt});
    check_val("mc_timeout", 32'(mc_timeout), 32'(m_to));
    check_val("stall_count", 32'(stall_count), 32'(sat(m_stall)));
    check_val("flush_count", 32'(flush_count), 32'(sat(m_flush)));
    check_val("state", 32'(dbg_state), 32'(m_mode));

    @(posedge clock);
    if (m_mode != M_HALT && !e_pc) m_stall++;
    if (flush_ev) m_flush++;
    m_mode = n_mode; m_wait = n_wait; m_drain_left = n_drain_left; m_to = n_to;
    @(negedge clock);
  endtask

  initial begin
    set_idle();
    model_init();
    do_reset();

    // Load-use on rs1, then the load leaves EX.
    step();
    ex_mem_read = 1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1;
    step();
    ex_mem_read = 0;
    step();
    check_val("lu_stall_once", 32'(stall_count), 32'd1);
    // No hazard through x0, through an unused source, and a hazard via rs2.
    ex_mem_read = 1; ex_rd = 5'd0; id_rs1 = 5'd0; step();
    ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 0; step();
    id_rs2 = 5'd5; id_uses_rs2 = 1; step();
    set_idle(); step();

    // Redirect beats a load-use hazard and a missing fetch.
    ex_mem_read = 1; ex_rd = 5'd7; id_rs1 = 5'd7; id_uses_rs1 = 1;
    ex_redirect = 1; imem_valid = 0;
    step();
    set_idle(); step();

    // Multi-cycle op completing on its tenth wait cycle.
    ex_mc_start = 1; step();
    ex_mc_start = 0;
    repeat (9) step();
    ex_mc_done = 1; step();
    ex_mc_done = 0; step();

    // Multi-cycle op that never completes.
    ex_mc_start = 1; step();
    ex_mc_start = 0;
    repeat (MC_TIMEOUT + 2) step();
    check_val("mc_timeout_sticky", 32'(mc_timeout), 32'd1);

    // Halt with the drain paused by a busy memory, and a redirect that must be ignored.
    halt_req = 1; step();
    halt_req = 0; step();
    dmem_busy = 1; ex_redirect = 1; step();
    ex_redirect = 0; step();
    dmem_busy = 0; step(); step();
    repeat (3) begin set_random(20); step(); end
    check_val("halt_stays", 32'(halted), 32'd1);
    set_idle();
    do_reset();

    // Long memory stall saturates the stall counter, then reset lands mid-wait.
    dmem_busy = 1;
    repeat (CNT_MAX + 5) step();
    dmem_busy = 0; ex_mc_start = 1; step();
    ex_mc_start = 0; repeat (3) step();
    do_reset();

    // Random traffic with periodic resets.
    begin
      int done_pct = 20;
      int halted_for = 0;
      for (int i = 0; i < 4000; i++) begin
        if ((m_mode == M_HALT && halted_for > 4) || $urandom_range(0, 299) == 0) begin
          halted_for = 0;
          case ($urandom_range(0, 2))
            0: done_pct = 0;
            1: done_pct = 5;
            default: done_pct = 25;
          endcase
          set_random(done_pct);
          do_reset();
        end
        if (m_mode == M_HALT) halted_for++;
        set_random(done_pct);
        step();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RV32 pipeline.
- Drives write-enable and flush for the PC and the IF/ID latch, and flush for the ID/EX latch, from:
  - load-use hazards,
  - taken branches/jumps resolved in EX,
  - instruction-fetch and data-memory wait states,
  - multi-cycle EX operations,
  - halt requests.
- Also provides saturating stall/flush performance counters.

Parameters:
- CNT_W, 32, width of stall_count and flush_count.
- DRAIN_CYCLES, 3, bubbles injected after halt request before freezing (EX/MEM/WB drain).
- MC_TIMEOUT, 64, max cycles in EX_WAIT before mc_timeout is flagged.

Ports:
- clock  in  1  pipeline clock; all state updates on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- id_rs1  in  5  rs1 of instruction in ID.
- id_rs2  in  5  rs2 of instruction in ID.
- id_uses_rs1  in  1  ID instruction reads rs1.
- id_uses_rs2  in  1  ID instruction reads rs2.
- ex_rd  in  5  destination of instruction in EX.
- ex_mem_read  in  1  EX instruction is a load.
- ex_redirect  in  1  taken branch/jump resolved in EX this cycle.
- ex_mc_start  in  1  multi-cycle EX op (div/rem) starts this cycle.
- ex_mc_done  in  1  multi-cycle EX op result ready.
- imem_valid  in  1  fetched instruction valid this cycle.
- dmem_busy  in  1  data memory not ready; MEM must hold.
- halt_req  in  1  halt instruction decoded in ID (pulse).
- pc_write  out  1  PC register load enable.
- ifid_write  out  1  IF/ID latch load enable.
- ifid_flush  out  1  load NOP into IF/ID.
- idex_flush  out  1  load bubble into ID/EX.
- back_hold  out  1  freeze EX/MEM and MEM/WB.
- halted  out  1  core frozen.
- mc_timeout  out  1  sticky: multi-cycle op exceeded MC_TIMEOUT.
- stall_count  out  CNT_W  cycles with pc_write=0 while not halted.
- flush_count  out  CNT_W  redirect flush events.

Behaviour:

Control outputs are combinational from state and inputs; counters, flags and FSM are registered.

While reset_n=0:
- State=RUN.
- pc_write=0, ifid_write=0, ifid_flush=1, idex_flush=1, back_hold=0.
- halted=0, mc_timeout=0, counters=0.
- Reset mid-operation aborts any state immediately.

Load-use hazard, lu:
- lu = ex_mem_read & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- x0 never causes a hazard.

States RUN / EX_WAIT / DRAIN / HALTED.

RUN: first matching rule applies.
1. dmem_busy: back_hold=1, pc_write=0, ifid_write=0, no flushes.
2. ex_redirect:
   - pc_write=1, ifid_flush=1, idex_flush=1.
   - flush_count++.
   - Redirect wins over lu and over !imem_valid.
3. ex_mc_start: pc_write=0, ifid_write=0; next state EX_WAIT, timer=0.
4. lu: pc_write=0, ifid_write=0, idex_flush=1. Exactly one bubble, since the hazard clears when the load leaves EX.
5. halt_req:
   - pc_write=0, ifid_flush=1.
   - ID/EX loads the halt instruction.
   - Next state DRAIN, drain counter=0.
6. !imem_valid: pc_write=0, ifid_flush=1 (bubble).
7. Otherwise pc_write=1, ifid_write=1, all flushes 0.

EX_WAIT:
- pc_write=0, ifid_write=0; back_hold=1 except on the exit cycle.
- idex_flush=0.
- The timer increments each cycle.
- On ex_mc_done, go to RUN; that cycle, back_hold=0 and the RUN rules for lu/redirect are not applied.
- When timer reaches MC_TIMEOUT-1 without done: set mc_timeout (sticky until reset) and go to RUN.
- dmem_busy is ignored in EX_WAIT.

DRAIN:
- pc_write=0, ifid_flush=1, idex_flush=1.
- ex_redirect and halt_req are ignored.
- dmem_busy asserts back_hold and pauses the drain counter.
- After DRAIN_CYCLES unpaused cycles, go to HALTED.

HALTED:
- halted=1, pc_write=0, ifid_write=0, back_hold=1, no flushes.
- Exit only by reset.

Counters:
- Saturate at all-ones; no wrap.
- stall_count increments on each cycle with pc_write=0 in RUN/EX_WAIT/DRAIN.
- Both counters +1 per cycle max.

Test Plan:
- lw x5 in EX (ex_mem_read=1, ex_rd=5); ID add with id_rs1=5, id_uses_rs1=1 -> one cycle of pc_write=0, ifid_write=0, idex_flush=1; next cycle pc_write=1; stall_count=1.
- Same with ex_rd=0, or with id_uses_rs1=0 -> no stall; pc_write=1 throughout.
- ex_redirect=1 together with lu=1 and imem_valid=0 -> pc_write=1, ifid_flush=1, idex_flush=1, flush_count=1, stall_count unchanged.
- ex_mc_start, then ex_mc_done after 10 cycles -> pc_write=0 for 11 cycles, back_hold=1 for 10; next cycle normal. With no done -> mc_timeout=1 after 64 cycles, state RUN.
- halt_req with dmem_busy high for 2 cycles mid-drain -> halted=1 after 5 cycles; redirect during DRAIN is ignored; halted stays 1 until reset_n=0.
- Force stall_count to all-ones via a long stall (CNT_W=4 build) -> holds at 15; assert reset_n low mid-EX_WAIT -> immediate reset outputs, counters 0.
